// File: rtl/lcd12864_reader_if.sv
// Command/response handshake plus ST7920 read-side pins for the LCD12864 reader.
// The slave side is the reader engine; the master side is its user/panel model.
interface lcd12864_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_type;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat_i;

    modport slave (
        input  req_valid, req_type, rsp_ready, lcd_dat_i,
        output req_ready, rsp_valid, rsp_data, rsp_timeout,
        output lcd_rs, lcd_rw, lcd_en
    );

    modport master (
        output req_valid, req_type, rsp_ready, lcd_dat_i,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout,
        input  lcd_rs, lcd_rw, lcd_en
    );
endinterface

// File: rtl/lcd12864_reader.sv
// ST7920 read-side bus engine: status reads, RAM reads with dummy cycle,
// and bounded busy-flag polling over the 6800-style parallel interface.
module lcd12864_reader #(
    parameter int SETUP_CYC = 4,
    parameter int EHIGH_CYC = 16,
    parameter int HOLD_CYC  = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd12864_reader_if.slave   bus
);

    localparam int MAX_SE = (SETUP_CYC > EHIGH_CYC) ? SETUP_CYC : EHIGH_CYC;
    localparam int MAXC   = (MAX_SE > HOLD_CYC) ? MAX_SE : HOLD_CYC;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW     = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EHIGH_LAST = CW'(EHIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [PW-1:0] POLL_MAX   = PW'(TIMEOUT);

    localparam logic [1:0] T_DATA = 2'b01;
    localparam logic [1:0] T_POLL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_CHECK,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [1:0]    type_q, type_d;
    logic          second_q, second_d;
    logic [7:0]    sample_q, sample_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic          rw_q, rw_d;
    logic          vld_q, vld_d;
    logic [7:0]    data_q, data_d;
    logic          to_q, to_d;
    logic [PW-1:0] poll_inc;

    assign poll_inc = poll_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        poll_d   = poll_q;
        type_d   = type_q;
        second_d = second_q;
        sample_d = sample_q;
        rs_d     = rs_q;
        rw_d     = rw_q;
        vld_d    = vld_q;
        data_d   = data_q;
        to_d     = to_q;

        unique case (state_q)
            S_IDLE: begin
                rw_d = 1'b0;
                if (bus.req_valid) begin
                    type_d   = bus.req_type;
                    rs_d     = (bus.req_type == T_DATA);
                    rw_d     = 1'b1;
                    poll_d   = '0;
                    second_d = 1'b0;
                    cnt_d    = '0;
                    to_d     = 1'b0;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_EHIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EHIGH: begin
                if (cnt_q == EHIGH_LAST) begin
                    sample_d = bus.lcd_dat_i;
                    cnt_d    = '0;
                    state_d  = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_RESP;
                if (type_q == T_DATA) begin
                    // First RAM read after an address set returns stale data
                    if (!second_q) begin
                        second_d = 1'b1;
                        state_d  = S_SETUP;
                    end
                end else if (type_q == T_POLL) begin
                    poll_d = poll_inc;
                    if (!sample_q[7]) begin
                        to_d = 1'b0;
                    end else if (poll_inc == POLL_MAX) begin
                        to_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                    end
                end
                if (state_d == S_RESP) begin
                    vld_d  = 1'b1;
                    data_d = sample_q;
                    rs_d   = 1'b0;
                    rw_d   = 1'b0;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        en_d = (state_d == S_EHIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            poll_q   <= '0;
            type_q   <= 2'b00;
            second_q <= 1'b0;
            sample_q <= 8'h00;
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            vld_q    <= 1'b0;
            data_q   <= 8'h00;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            poll_q   <= poll_d;
            type_q   <= type_d;
            second_q <= second_d;
            sample_q <= sample_d;
            en_q     <= en_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            to_q     <= to_d;
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = vld_q;
    assign bus.rsp_data    = data_q;
    assign bus.rsp_timeout = to_q;
    assign bus.lcd_en      = en_q;
    assign bus.lcd_rs      = rs_q;
    assign bus.lcd_rw      = rw_q;

endmodule

// File: tb/tb_lcd12864_reader.sv
// Directed bench for lcd12864_reader with a small ST7920 read-data model.
// The DUT is built with TIMEOUT = 8 so the poll timeout path is short.
module tb_lcd12864_reader;

    localparam int EH = 16;

    logic clk;
    logic rst_n;

    lcd12864_reader_if bus ();

    lcd12864_reader #(
        .SETUP_CYC(4),
        .EHIGH_CYC(EH),
        .HOLD_CYC(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [63:0] d;
        int          np;
        logic [7:0]  exp_data;
        logic        exp_to;
        int          exp_lat;
        logic        exp_rs;
    } vec_t;

    int checks;
    int errors;

    logic [7:0] mdl [8];
    int         pulses;
    int         base_g;
    int         cur_w;
    int         bad_w;
    int         viol;
    logic       en_prev;
    logic       exp_rs_g;
    int         mk;
    logic [7:0] model_byte;

    // Panel model: byte returned depends on which E pulse of the command is active
    always_comb begin
        mk = pulses - base_g - 1;
        if (mk < 0) mk = 0;
        if (mk > 7) mk = 7;
        model_byte = mdl[mk];
    end
    assign bus.lcd_dat_i = model_byte;

    initial begin
        pulses  = 0;
        cur_w   = 0;
        bad_w   = 0;
        viol    = 0;
        en_prev = 1'b0;
    end

    always @(negedge clk) begin
        en_prev <= bus.lcd_en;
        if (bus.lcd_en && !en_prev) begin
            pulses <= pulses + 1;
            cur_w  <= 1;
        end else if (bus.lcd_en) begin
            cur_w <= cur_w + 1;
        end
        if (!bus.lcd_en && en_prev && cur_w != EH) bad_w <= bad_w + 1;
        if (bus.lcd_en && (bus.lcd_rw !== 1'b1 || bus.lcd_rs !== exp_rs_g))
            viol <= viol + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int vb;
        int wb;
        bit got;
        @(negedge clk);
        for (int i = 0; i < 8; i++) mdl[i] = v.d[8*i +: 8];
        exp_rs_g = v.exp_rs;
        base_g   = pulses;
        vb       = viol;
        wb       = bad_w;
        n = 0;
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d req_ready", idx), bus.req_ready, 1);
        bus.req_type  = v.typ;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n   = 0;
        got = 0;
        while (!got && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.rsp_valid) got = 1;
        end
        chk($sformatf("v%0d rsp seen", idx), got, 1);
        chk($sformatf("v%0d latency", idx), n + 1, v.exp_lat);
        chk($sformatf("v%0d data", idx), bus.rsp_data, v.exp_data);
        chk($sformatf("v%0d timeout", idx), bus.rsp_timeout, v.exp_to);
        chk($sformatf("v%0d pulses", idx), pulses - base_g, v.np);
        chk($sformatf("v%0d rs/rw", idx), viol - vb, 0);
        chk($sformatf("v%0d e width", idx), bad_w - wb, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d rsp drop", idx), bus.rsp_valid, 0);
        chk($sformatf("v%0d idle", idx), bus.req_ready, 1);
    endtask

    vec_t vt [6];

    initial begin
        int   n;
        int   pb;
        bit   seen;
        vec_t v;

        checks = 0;
        errors = 0;
        base_g = 0;
        exp_rs_g = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

        vt[0] = '{2'b00, 64'h8A8A8A8A8A8A8A8A, 1, 8'h8A, 1'b0, 26, 1'b0};
        vt[1] = '{2'b01, 64'h41414141414141FF, 2, 8'h41, 1'b0, 51, 1'b1};
        vt[2] = '{2'b10, 64'h0505050505808080, 4, 8'h05, 1'b0, 101, 1'b0};
        vt[3] = '{2'b10, 64'h8080808080808080, 8, 8'h80, 1'b1, 201, 1'b0};
        vt[4] = '{2'b11, 64'h3C3C3C3C3C3C3C3C, 1, 8'h3C, 1'b0, 26, 1'b0};
        vt[5] = '{2'b10, 64'h0000000000000000, 1, 8'h00, 1'b0, 26, 1'b0};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_type  = 2'b00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst lcd_en", bus.lcd_en, 0);
        chk("rst lcd_rw", bus.lcd_rw, 0);
        chk("rst lcd_rs", bus.lcd_rs, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_data", bus.rsp_data, 0);
        chk("rst rsp_timeout", bus.rsp_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst req_ready", bus.req_ready, 1);

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Backpressure with a second request already waiting
        @(negedge clk);
        for (int i = 0; i < 8; i++) mdl[i] = 8'h5A;
        exp_rs_g      = 1'b0;
        base_g        = pulses;
        bus.rsp_ready = 1'b0;
        bus.req_type  = 2'b00;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp rsp seen", bus.rsp_valid, 1);
        pb = pulses;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp stall", {bus.rsp_valid, bus.req_ready, bus.rsp_data},
                {1'b1, 1'b0, 8'h5A});
        end
        chk("bp no pulse", pulses - pb, 0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp released", {bus.rsp_valid, bus.req_ready}, 2'b01);
        @(posedge clk);
        #1;
        chk("bp next accept", {bus.req_ready, bus.lcd_rw}, 2'b01);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("bp next data", bus.rsp_data, 8'h5A);
        @(posedge clk);

        // Reset during the first E pulse of a data read
        @(negedge clk);
        exp_rs_g      = 1'b1;
        bus.req_type  = 2'b01;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.lcd_en && n < 50) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("mid rst e high", bus.lcd_en, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid rst en/rw", {bus.lcd_en, bus.lcd_rw}, 2'b00);
        chk("mid rst valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid rst ready", bus.req_ready, 1);
        pb   = pulses;
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid || bus.lcd_en) seen = 1;
        end
        chk("mid rst quiet", seen, 0);
        chk("mid rst pulses", pulses - pb, 0);
        v = '{2'b11, 64'hA7A7A7A7A7A7A7A7, 1, 8'hA7, 1'b0, 26, 1'b0};
        run_vec(v, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd12864_reader.md
Name: lcd12864_reader

Overview:
- Read-side bus engine for the ST7920-based LCD12864 panel on the 8-bit 6800-style parallel interface (RS, RW, E, DB[7:0]).
- Runs status reads (busy flag BF + address counter AC) and display-RAM data reads, including the ST7920 dummy read.
- Also offers a busy-flag poll command, so write sequencers can wait on BF instead of fixed delays.
- Sits beside the panel write sequencer. A top-level arbiter grants this block the RS/RW/E pins; while that grant is held, the panel data pins are inputs.

Parameters:
- SETUP_CYC, 4: clocks RS/RW are stable with E low before E rises (tAS). Must be >= 1.
- EHIGH_CYC, 16: clocks E is held high (PW_EH). Must be >= 2.
- HOLD_CYC, 4: clocks E is low, RS/RW still held, after E falls (tAH). Must be >= 1.
- TIMEOUT, 1024: maximum status reads in one busy-poll command. Must be >= 1.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: synchronous active-low reset.
- req_valid, input, 1: command request.
- req_ready, output, 1: block idle; a request is accepted when req_valid && req_ready.
- req_type, input, 2: 00 = status read, 01 = data read, 10 = busy poll, 11 = reserved (executed as a status read).
- rsp_valid, output, 1: response available.
- rsp_ready, input, 1: consumer accepts the response.
- rsp_data, output, 8: byte read (status byte or RAM byte).
- rsp_timeout, output, 1: busy poll ended with BF still 1.
- lcd_rs, output, 1: register select.
- lcd_rw, output, 1: 1 = read.
- lcd_en, output, 1: enable strobe.
- lcd_dat_i, input, 8: panel data bus, input direction.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - lcd_en = 0, lcd_rw = 0, lcd_rs = 0.
  - rsp_valid = 0, rsp_data = 0x00, rsp_timeout = 0.
  - Poll count = 0, phase counter = 0.
  - req_ready = 1 from the first cycle after rst_n returns high.
- Reset mid-operation: lcd_en is 0 on the next clock. No response is produced. Any partially sampled data is discarded.
- States: IDLE, SETUP, EHIGH, HOLD, CHECK, RESP.
- IDLE:
  - req_ready = 1, lcd_en = 0, lcd_rw = 0.
  - On accept, latch req_type, set lcd_rs (1 for data read, else 0), set lcd_rw = 1, clear poll count, go to SETUP.
- Each read pulse:
  - SETUP: SETUP_CYC cycles, lcd_en = 0.
  - EHIGH: EHIGH_CYC cycles, lcd_en = 1.
  - lcd_dat_i is registered into the sample register on the last EHIGH cycle.
  - HOLD: HOLD_CYC cycles, lcd_en = 0.
  - lcd_rs and lcd_rw are constant from SETUP through HOLD.
- All outputs are registered. lcd_en is glitch-free and changes only at state boundaries.
- CHECK (one cycle after HOLD) selects the next state:
  - Status read: go to RESP.
  - Data read, first pulse (dummy): discard the sample, go to SETUP for a second pulse.
  - Data read, second pulse: go to RESP.
  - Busy poll:
    - Increment poll count.
    - Sample bit7 = 0: go to RESP, rsp_timeout = 0.
    - Else, poll count == TIMEOUT: go to RESP, rsp_timeout = 1.
    - Else: go to SETUP.
- RESP:
  - rsp_valid = 1. rsp_data = last sample. lcd_rw = 0, lcd_rs = 0.
  - rsp_valid, rsp_data and rsp_timeout stay stable until rsp_ready.
  - On the rsp_valid && rsp_ready cycle: go to IDLE, rsp_valid = 0 next cycle.
  - req_ready = 0 throughout. A req_valid seen in RESP is not accepted.
- Latency with defaults, accept in cycle T and rsp_ready held high:
  - One pulse = SETUP_CYC + EHIGH_CYC + HOLD_CYC + 1 (CHECK) = 25 cycles.
  - rsp_valid first high at T+1+25 = T+26 for a status read.
  - Data read: T+51. Busy poll with k reads: T+1+25k.
- Poll count width is clog2(TIMEOUT+1). The phase counter is sized for max(SETUP_CYC, EHIGH_CYC, HOLD_CYC).
- TIMEOUT = 1 degenerates to a single status read plus the BF check.

Test Plan:
1. Status read, lcd_dat_i = 0x8A constant, rsp_ready = 1 → one E pulse exactly 16 cycles wide; rs = 0, rw = 1 throughout; rsp_valid first at accept+26; rsp_data = 0x8A, rsp_timeout = 0.
2. Data read, model returns 0xFF during the first E pulse and 0x41 during the second → two E pulses, rs = 1; rsp_data = 0x41; rsp_valid at accept+51.
3. Busy poll, model returns 0x80 for reads 1–3 and 0x05 for read 4 → exactly 4 E pulses; rsp_data = 0x05, rsp_timeout = 0, rsp_valid at accept+101.
4. Busy poll with TIMEOUT = 8, model stuck at 0x80 → exactly 8 pulses; rsp_data = 0x80, rsp_timeout = 1.
5. Backpressure: rsp_ready low for 10 cycles after rsp_valid, req_valid held high → rsp_data stable, req_ready = 0, no new E pulse; after rsp_ready, IDLE then next request accepted.
6. rst_n low for one cycle during EHIGH of a data read → lcd_en = 0 next cycle, lcd_rw = 0, rsp_valid never asserted; req_ready = 1 after release; a following req_type = 11 runs as a status read.
